// File: rtl/rot_arb_pkg.sv
// Shared definitions for rot_arb and other clients of the rot barrel rotator.
//   REQ0 / REQ1    : requester indices used for grant, ptr and out_src
//   left_to_right(): converts a left-rotate amount to rot's native right amount
package rot_arb_pkg;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Width of the amount argument to left_to_right; callers cast in and out.
  localparam int unsigned AMT_W = 32;

  // (2^log2_n - k) mod 2^log2_n; k = 0 maps to 0.
  function automatic logic [AMT_W-1:0] left_to_right(input logic [AMT_W-1:0] k,
                                                     input int unsigned       log2_n);
    logic [AMT_W-1:0] mask;
    mask = (AMT_W'(1) << log2_n) - AMT_W'(1);
    return (AMT_W'(0) - k) & mask;
  endfunction

endpackage

// File: rtl/rot.sv
// Combinational N-bit barrel rotator, native right rotate.
//   in_bits  [0:N-1]      : input data, index 0 is the MSB
//   k        [0:log2_N-1] : rotate amount, index 0 is the LSB (stage order)
//   out_bits [0:N-1]      : out_bits[i] = in_bits[(i - k) mod N]
module rot #(
  parameter int unsigned N      = 8192,
  parameter int unsigned log2_N = 13
) (
  input  logic [0:N-1]      in_bits,
  input  logic [0:log2_N-1] k,
  output logic [0:N-1]      out_bits
);

  logic [0:N-1] stg [0:log2_N];

  assign stg[0] = in_bits;

  // Stage s rotates by 2^s toward higher indices when k[s] is set.
  for (genvar s = 0; s < log2_N; s++) begin : g_stage
    localparam int unsigned SH = 32'(1) << s;
    assign stg[s+1] = k[s] ? {stg[s][N-SH +: SH], stg[s][0 +: N-SH]} : stg[s];
  end

  assign out_bits = stg[log2_N];

endmodule

// File: rtl/rot_arb.sv
// Two-requester round-robin front end for one shared rot instance.
// One accept per cycle, result registered with 1-cycle latency.
//   clk, rst (sync, active high)
//   reqX_valid/ready/bits/k/left : request channels; k index 0 is the LSB,
//                                  left=1 requests a left rotate
//   out_valid/ready/bits/src     : one-entry registered result stage
module rot_arb
  import rot_arb_pkg::*;
#(
  parameter int unsigned N      = 8192,
  parameter int unsigned log2_N = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [0:N-1]      req0_bits,
  input  logic [0:log2_N-1] req0_k,
  input  logic              req0_left,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [0:N-1]      req1_bits,
  input  logic [0:log2_N-1] req1_k,
  input  logic              req1_left,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:N-1]      out_bits,
  output logic              out_src
);

  logic              ptr;
  logic              can_accept_c;
  logic              grant_valid_c;
  logic              grant_c;
  logic              accept_c;
  logic [0:N-1]      sel_bits_c;
  logic [0:log2_N-1] sel_k_c;
  logic              sel_left_c;
  logic [log2_N-1:0] k_num_c;
  logic [log2_N-1:0] k_eff_num_c;
  logic [0:log2_N-1] k_eff_c;
  logic [0:N-1]      rot_bits_c;

  // Grant: lone requester wins; on contention ptr decides.
  always_comb begin
    grant_valid_c = req0_valid | req1_valid;
    grant_c       = REQ0;
    if (req0_valid & req1_valid) begin
      grant_c = ptr;
    end else if (req1_valid) begin
      grant_c = REQ1;
    end
  end

  // Output slot is free or draining this cycle; nothing is accepted in reset.
  assign can_accept_c = ~rst & (~out_valid | out_ready);
  assign req0_ready   = can_accept_c & grant_valid_c & (grant_c == REQ0);
  assign req1_ready   = can_accept_c & grant_valid_c & (grant_c == REQ1);
  assign accept_c     = (req0_ready & req0_valid) | (req1_ready & req1_valid);

  // Granted request mux.
  always_comb begin
    sel_bits_c = req0_bits;
    sel_k_c    = req0_k;
    sel_left_c = req0_left;
    if (grant_c == REQ1) begin
      sel_bits_c = req1_bits;
      sel_k_c    = req1_k;
      sel_left_c = req1_left;
    end
  end

  // Port k is LSB-at-index-0; re-order to a numeric vector and back.
  for (genvar j = 0; j < log2_N; j++) begin : g_k_order
    assign k_num_c[j] = sel_k_c[j];
    assign k_eff_c[j] = k_eff_num_c[j];
  end

  assign k_eff_num_c = sel_left_c ? log2_N'(left_to_right(AMT_W'(k_num_c), log2_N))
                                  : k_num_c;

  rot #(
    .N      (N),
    .log2_N (log2_N)
  ) u_rot (
    .in_bits  (sel_bits_c),
    .k        (k_eff_c),
    .out_bits (rot_bits_c)
  );

  // Result register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_bits  <= '0;
      out_src   <= REQ0;
      ptr       <= REQ0;
    end else if (accept_c) begin
      out_valid <= 1'b1;
      out_bits  <= rot_bits_c;
      out_src   <= grant_c;
      ptr       <= ~grant_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rot_arb.sv
// Bench for rot_arb at N=16: vector table plus reset/backpressure sequences,
// with a scoreboard of expected results checked on the output handshake.
module tb_rot_arb;

  localparam int unsigned N  = 16;
  localparam int unsigned LN = 4;

  logic          clk;
  logic          rst;
  logic          req0_valid, req0_ready, req0_left;
  logic [0:N-1]  req0_bits;
  logic [0:LN-1] req0_k;
  logic          req1_valid, req1_ready, req1_left;
  logic [0:N-1]  req1_bits;
  logic [0:LN-1] req1_k;
  logic          out_valid, out_ready, out_src;
  logic [0:N-1]  out_bits;

  rot_arb #(.N(N), .log2_N(LN)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_bits(req0_bits),
    .req0_k(req0_k), .req0_left(req0_left),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_bits(req1_bits),
    .req1_k(req1_k), .req1_left(req1_left),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .out_src(out_src)
  );

  typedef struct {
    logic        v0; logic [15:0] b0; int k0; logic l0;
    logic        v1; logic [15:0] b1; int k1; logic l1;
    logic        r0; logic r1;
  } vec_t;

  typedef struct {
    logic [15:0] bits;
    logic        src;
    int          due;
  } exp_t;

  localparam int NV = 16;
  vec_t vecs [0:NV-1];
  exp_t sb [$];
  int   n_checks = 0, n_fail = 0, n_push = 0, n_pop = 0, cyc = 0;
  int   cur_k0 = 0, cur_k1 = 0;
  logic head_seen = 1'b0;
  logic [15:0] held;

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end
  initial begin #200000; $display("FAIL watchdog: no finish after 200000 time units"); $fatal(1); end

  // Rotate right by k_eff where bit index 0 is the MSB (numeric ror).
  function automatic logic [15:0] model(input logic [15:0] x, input int k, input logic left);
    int ke;
    logic [31:0] d;
    ke = left ? (16 - k) % 16 : k;
    d  = {x, x} >> ke;
    return d[15:0];
  endfunction

  function automatic vec_t mk(input logic v0, input logic [15:0] b0, input int k0, input logic l0,
                              input logic v1, input logic [15:0] b1, input int k1, input logic l1,
                              input logic r0, input logic r1);
    vec_t v;
    v.v0 = v0; v.b0 = b0; v.k0 = k0; v.l0 = l0;
    v.v1 = v1; v.b1 = b1; v.k1 = k1; v.l1 = l1;
    v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic v0, input logic [15:0] b0, input int k0, input logic l0,
                       input logic v1, input logic [15:0] b1, input int k1, input logic l1);
    req0_valid = v0; req0_bits = b0; req0_left = l0; cur_k0 = k0;
    req1_valid = v1; req1_bits = b1; req1_left = l1; cur_k1 = k1;
    for (int j = 0; j < 4; j++) begin
      req0_k[j] = k0[j];
      req1_k[j] = k1[j];
    end
  endtask

  // Check both readies against expectation and record the accepted request.
  task automatic step(input string name, input logic er0, input logic er1);
    exp_t e;
    check({name, "_ready0"}, 32'(req0_ready), 32'(er0));
    check({name, "_ready1"}, 32'(req1_ready), 32'(er1));
    e.due = cyc + 1;
    if (er0 && req0_valid) begin
      e.bits = model(req0_bits, cur_k0, req0_left); e.src = 1'b0;
      sb.push_back(e); n_push++;
    end else if (er1 && req1_valid) begin
      e.bits = model(req1_bits, cur_k1, req1_left); e.src = 1'b1;
      sb.push_back(e); n_push++;
    end
  endtask

  // Output monitor: latency on first appearance, data on handshake.
  initial forever begin
    @(negedge clk);
    if (!rst && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb_empty: got out_valid=1, expected no result (cycle %0d)", cyc);
      end else begin
        if (!head_seen) begin
          check("latency", 32'(cyc), 32'(sb[0].due));
          head_seen = 1'b1;
        end
        if (out_ready) begin
          check("out_bits", 32'(out_bits), 32'(sb[0].bits));
          check("out_src", 32'(out_src), 32'(sb[0].src));
          void'(sb.pop_front());
          n_pop++;
          head_seen = 1'b0;
        end
      end
    end
  end

  initial begin
    vecs[0]  = mk(1, 16'h0003, 1, 0, 1, 16'hFFFF, 5, 0, 1, 0);
    vecs[1]  = mk(1, 16'h8000, 3, 0, 0, 16'h0000, 0, 0, 1, 0);
    vecs[2]  = mk(0, 16'h0000, 0, 0, 1, 16'h8000, 3, 1, 0, 1);
    vecs[3]  = mk(1, 16'hA5C3, 0, 1, 0, 16'h0000, 0, 0, 1, 0);
    vecs[4]  = mk(0, 16'h0000, 0, 0, 1, 16'h1234, 0, 0, 0, 1);
    vecs[5]  = mk(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    for (int i = 6; i < 12; i++)
      vecs[i] = mk(1, 16'h0001, 1, 0, 1, 16'h0100, 4, 0, (i % 2) == 0, (i % 2) == 1);
    vecs[12] = mk(1, 16'h00F0, 15, 1, 0, 16'h0000, 0, 0, 1, 0);
    vecs[13] = mk(1, 16'h0F00, 2, 0, 1, 16'hC000, 8, 1, 0, 1);
    vecs[14] = mk(1, 16'h0F00, 2, 0, 1, 16'hC000, 8, 1, 1, 0);
    vecs[15] = mk(0, 16'h0000, 0, 0, 1, 16'h0F0F, 7, 1, 0, 1);

    // Reset held two cycles with both requesters valid.
    rst = 1'b1; out_ready = 1'b1;
    drive(1, 16'h1111, 1, 0, 1, 16'h2222, 2, 0);
    repeat (2) begin
      @(posedge clk); #4;
      check("rst_ready0", 32'(req0_ready), 32'd0);
      check("rst_ready1", 32'(req1_ready), 32'd0);
    end
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bits", 32'(out_bits), 32'h0);
    check("rst_out_src", 32'(out_src), 32'd0);
    drive(0, 16'h0, 0, 0, 0, 16'h0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].v0, vecs[i].b0, vecs[i].k0, vecs[i].l0,
            vecs[i].v1, vecs[i].b1, vecs[i].k1, vecs[i].l1);
      #3 step($sformatf("vec%0d", i), vecs[i].r0, vecs[i].r1);
    end
    @(posedge clk); #1 drive(0, 16'h0, 0, 0, 0, 16'h0, 0, 0);

    // Backpressure: hold a result for 5 cycles with both requesters waiting.
    @(posedge clk); #1 drive(1, 16'h00FF, 4, 0, 0, 16'h0, 0, 0);
    #3 step("bp_load", 1, 0);
    held = model(16'h00FF, 4, 0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      drive(1, 16'h3C00, 2, 1, 1, 16'h0007, 3, 0);
      #3 step($sformatf("bp_hold%0d", c), 0, 0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_bits", 32'(out_bits), 32'(held));
      check("bp_out_src", 32'(out_src), 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    #3 step("bp_release", 0, 1);
    @(posedge clk); #1 drive(1, 16'h3C00, 2, 1, 0, 16'h0, 0, 0);
    #3 step("bp_pending0", 1, 0);
    @(posedge clk); #1 drive(0, 16'h0, 0, 0, 0, 16'h0, 0, 0);
    #3 step("bp_idle", 0, 0);
    repeat (2) @(posedge clk);

    // Reset while a result is held and both requesters are valid.
    #1 drive(1, 16'h4000, 1, 0, 0, 16'h0, 0, 0);
    #3 step("mrst_load", 1, 0);
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b0;
    drive(1, 16'h0300, 5, 1, 1, 16'h0060, 6, 0);
    #3;
    check("mrst_held_valid", 32'(out_valid), 32'd1);
    check("mrst_ready0", 32'(req0_ready), 32'd0);
    check("mrst_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    n_push -= sb.size();
    sb.delete();
    head_seen = 1'b0;
    #3;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_out_bits", 32'(out_bits), 32'h0);
    step("mrst_first", 1, 0);
    @(posedge clk); #1 drive(0, 16'h0, 0, 0, 1, 16'h0060, 6, 0);
    #3 step("mrst_second", 0, 1);
    @(posedge clk); #1 drive(0, 16'h0, 0, 0, 0, 16'h0, 0, 0);

    for (int c = 0; c < 10 && sb.size() > 0; c++) @(posedge clk);
    @(posedge clk); #4;
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("xfer_count", 32'(n_pop), 32'(n_push));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rot_arb.md
Name: rot_arb

Overview:
- Two-requester front end for the combinational barrel rotator `rot`.
- Arbitrates round-robin between two valid/ready request channels and converts left-rotate requests to the rotator's native amount.
- Drives one shared `rot` instance and registers its result into a one-entry output stage with valid/ready backpressure.
- Lets multiple producers share one N-bit rotator at full throughput: one accept per cycle, 1-cycle latency.

Parameters:
- N, 8192, datapath width in bits; power of two, N >= 4.
- log2_N, 13, rotate-amount width; must equal log2(N).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 offers a request.
- req0_ready  output  1  requester 0 request accepted this cycle.
- req0_bits  input  [0:N-1]  requester 0 data; index 0 is the MSB.
- req0_k  input  [0:log2_N-1]  requester 0 rotate amount; index 0 is the LSB, matching `rot` stage order.
- req0_left  input  1  1 = left rotate, 0 = right rotate (native).
- req1_valid / req1_ready / req1_bits / req1_k / req1_left  same as requester 0, for requester 1.
- out_valid  output  1  registered result available.
- out_ready  input  1  consumer takes the result.
- out_bits  output  [0:N-1]  rotated data.
- out_src  output  1  index of the requester that produced out_bits.

Behaviour:
- Rotation semantics (native right rotate): out[i] = in[(i - k_eff) mod N] for all i.
  - req_left=0: k_eff = k.
  - req_left=1: k_eff = (N - k) mod N, computed in log2_N bits with wrap; k=0 gives k_eff=0.
- can_accept = ~out_valid | out_ready. This allows a new accept in the same cycle the held result drains.
- Grant, evaluated combinationally each cycle:
  - Only one requester valid: grant that requester.
  - Both valid: grant the requester `ptr` points to.
  - Neither valid: no grant.
- reqX_ready = can_accept & grant==X. At most one ready is high per cycle.
- reqX_ready may depend on reqX_valid. Requesters must not make valid depend on ready.
- Accept (a ready is high and its valid is high):
  - Next cycle: out_bits = rot(bits, k_eff) of the granted request, out_src = X, out_valid = 1.
  - Latency is exactly 1 cycle, with no bubble under continuous traffic.
- ptr update: after an accept from requester X, ptr <= ~X. With no accept, ptr holds. Consequences:
  - Under continuous contention, grants alternate 0,1,0,1.
  - A lone requester is never blocked.
- Output hold rules:
  - out_valid=1 & out_ready=0 & no accept: out_bits, out_src and out_valid hold stable.
  - out_valid=1 & out_ready=1 & no accept: out_valid <= 0 next cycle; out_bits/out_src are don't-care but held.
- Requests must hold bits/k/left stable while valid & ~ready. No internal request buffering.
- Reset (rst=1 at a clock edge):
  - out_valid <= 0, out_bits <= 0, out_src <= 0, ptr <= 0.
  - Both ready outputs are 0 during reset.
  - Reset mid-transfer discards any held result; no partial output.
- Only out_bits, out_src, out_valid and ptr are flops; the rotator datapath is purely combinational.

Decomposition:
- Shared package: localparam REQ0=0, REQ1=1; a function computing left-to-right amount conversion ((N-k) mod N) for reuse by other rot clients.
- Sub-module: one instance of the existing `rot` (parameters N, log2_N passed through), fed by the granted request mux and k_eff.
- Arbiter and output register stay inline in rot_arb; no further split.

Test Plan:
All scenarios use N=16, log2_N=4; data written as hex, bit index 0 = MSB.
- Reset: hold rst for 2 cycles with both valids high -> both readies 0; after release out_valid=0, out_bits=0x0000, ptr=0.
- Native rotate: req0 only, bits=0x8000, k=3, left=0, out_ready=1 -> req0_ready=1; next cycle out_valid=1, out_bits=0x1000, out_src=0.
- Left rotate: req1 only, bits=0x8000, k=3, left=1 -> out_bits=0x0004 (k_eff=13), out_src=1.
- Left rotate with k=0 -> out_bits equals input.
- Contention and fairness: both valid continuously for 6 cycles, out_ready=1, req0 bits=0x0001 k=1, req1 bits=0x0100 k=4 -> out_src sequence 0,1,0,1,0,1; out_bits alternate 0x8000, 0x0010; one result per cycle.
- Backpressure: out_ready=0 while out_valid=1 -> both readies 0 and out_bits/out_src stable for 5 cycles; raise out_ready -> same-cycle accept of the pending request, new result next cycle, no lost or duplicated transfer (scoreboard count match).
- Reset mid-stream: assert rst while out_valid=1 and both requesters valid -> out_valid=0 next cycle, the held result is never consumed, ptr=0 so req0 is granted first after release.
